// File: rtl/spi_host_bridge_pkg.sv
// Shared constants and types for the host-to-SPI bridge: register map, CTRL
// bit positions, RX FIFO geometry and the shift-engine state encoding.
package spi_host_bridge_pkg;

  localparam logic [2:0] REG_TX   = 3'd0;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_DIV  = 3'd5;
  localparam logic [2:0] REG_SS   = 3'd6;

  localparam int CTRL_ASS     = 13;
  localparam int CTRL_IE      = 12;
  localparam int CTRL_LSB     = 11;
  localparam int CTRL_TX_NEG  = 10;
  localparam int CTRL_RX_NEG  = 9;
  localparam int CTRL_GO      = 8;
  localparam int CTRL_LEN_MSB = 5;
  localparam int CTRL_W       = 14;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_PTR_W  = 4;
  localparam int FIFO_CNT_W  = 5;
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } engine_state_e;

  // A CHAR_LEN field of zero encodes a full 32-bit character.
  function automatic logic [5:0] char_len(input logic [5:0] field);
    return (field == 6'd0) ? 6'd32 : field;
  endfunction

endpackage

// File: rtl/spi_host_bridge_if.sv
// Host endpoint bundle: command word + strobes in, interrupt and FIFO/echo data out.
// Handshake: trigger and readFifo are single-cycle strobes with no ready; the bridge always accepts.
interface spi_host_bridge_if;
  logic [31:0] ep_dataout;
  logic        trigger;
  logic        readFifo;
  logic        rstFifo;
  logic        hostinterrupt;
  logic [31:0] dout;
  logic [31:0] lastWrite;

  modport master (
    output ep_dataout, trigger, readFifo, rstFifo,
    input  hostinterrupt, dout, lastWrite
  );

  modport slave (
    input  ep_dataout, trigger, readFifo, rstFifo,
    output hostinterrupt, dout, lastWrite
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master core: sclk divider, TX/RX shift registers and edge counter, with
// MOSI looped straight back to MISO. State is exported for observation.
module spi_shift_engine
  import spi_host_bridge_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          go_i,
  input  logic [31:0]   tx_data_i,
  input  logic [5:0]    len_i,
  input  logic          lsb_i,
  input  logic          tx_neg_i,
  input  logic          rx_neg_i,
  input  logic [15:0]   divider_i,
  output engine_state_e state_o,
  output logic          sclk_o,
  output logic          done_o,
  output logic [31:0]   rx_word_o
);

  engine_state_e state_q, state_d;
  logic [15:0] div_cnt_q;
  logic        sclk_q;
  logic [6:0]  edge_cnt_q;
  logic [31:0] tx_sr_q;
  logic [31:0] rx_sr_q;
  logic        pending_q;

  logic start, toggle, rise, fall, sample_edge, drive_edge, last_edge, mosi, miso;

  assign start       = (state_q == ST_IDLE) && go_i;
  assign toggle      = (state_q == ST_RUN) && (div_cnt_q == divider_i);
  assign rise        = toggle && !sclk_q;
  assign fall        = toggle && sclk_q;
  assign sample_edge = rx_neg_i ? fall : rise;
  assign drive_edge  = tx_neg_i ? fall : rise;
  assign last_edge   = toggle && (edge_cnt_q == ({len_i, 1'b0} - 7'd1));
  assign mosi        = lsb_i ? tx_sr_q[0] : tx_sr_q[31];
  assign miso        = mosi;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_i) state_d = ST_RUN;
      ST_RUN:  if (last_edge) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    state_o = state_q;
    sclk_o  = sclk_q;
    done_o  = (state_q == ST_DONE);
  end

  // A drive edge only advances TX once the presented bit has been sampled,
  // so loopback data is independent of the TX_NEG/RX_NEG edge choice.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      edge_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      pending_q  <= 1'b0;
    end else if (start) begin
      div_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      edge_cnt_q <= '0;
      rx_sr_q    <= '0;
      pending_q  <= 1'b0;
      tx_sr_q    <= lsb_i ? tx_data_i : (tx_data_i << (6'd32 - len_i));
    end else if (state_q == ST_RUN) begin
      if (toggle) begin
        div_cnt_q  <= '0;
        sclk_q     <= ~sclk_q;
        edge_cnt_q <= edge_cnt_q + 7'd1;
      end else begin
        div_cnt_q  <= div_cnt_q + 16'd1;
      end
      if (sample_edge)
        rx_sr_q <= lsb_i ? {miso, rx_sr_q[31:1]} : {rx_sr_q[30:0], miso};
      if (drive_edge && (sample_edge || pending_q))
        tx_sr_q <= lsb_i ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      if (sample_edge && !drive_edge) pending_q <= 1'b1;
      else if (drive_edge)            pending_q <= 1'b0;
    end
  end

  // LSB-first characters accumulate at the top and are right-justified here.
  assign rx_word_o = lsb_i ? (rx_sr_q >> (6'd32 - len_i)) : rx_sr_q;

endmodule

// File: rtl/spi_host_bridge.sv
// Host command decoder, SPI register set and 16x32 RX FIFO around spi_shift_engine.
// Define SPI_FIFO_FWFT_EN for a first-word-fall-through dout; default is a registered dout.
module spi_host_bridge
  import spi_host_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  spi_host_bridge_if.slave      host,
  output engine_state_e         dbg_state_o,
  output logic [FIFO_CNT_W-1:0] dbg_fifo_count_o,
  output logic                  dbg_sclk_o,
  output logic [7:0]            dbg_ss_n_o,
  output logic [CTRL_W-1:0]     dbg_ctrl_o
);

  logic [2:0]        addr_sel_q;
  logic              addr_en_q;
  logic [31:0]       tx_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       div_q;
  logic [7:0]        ss_q;
  logic [31:0]       last_write_q;

  engine_state_e eng_state;
  logic          eng_done;
  logic [31:0]   rx_word;
  logic          busy;
  logic [1:0]    cmd;

  assign cmd  = host.ep_dataout[31:30];
  assign busy = (eng_state != ST_IDLE) || ctrl_q[CTRL_GO];

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_sel_q   <= '0;
      addr_en_q    <= 1'b0;
      tx_q         <= '0;
      ctrl_q       <= '0;
      div_q        <= '0;
      ss_q         <= '0;
      last_write_q <= '0;
    end else begin
      if (host.trigger) begin
        last_write_q <= host.ep_dataout;
        if (cmd == 2'b10) begin
          addr_sel_q <= host.ep_dataout[6:4];
          addr_en_q  <= host.ep_dataout[0];
        end else if ((cmd == 2'b01) && addr_en_q) begin
          case (addr_sel_q)
            REG_TX:   if (!busy) tx_q   <= {2'b00, host.ep_dataout[29:0]};
            REG_CTRL: if (!busy) ctrl_q <= host.ep_dataout[CTRL_W-1:0];
            REG_DIV:  if (!busy) div_q  <= host.ep_dataout[15:0];
            REG_SS:   ss_q <= host.ep_dataout[7:0];
            default:  ;
          endcase
        end
      end
      if (eng_done) ctrl_q[CTRL_GO] <= 1'b0;
    end
  end

  spi_shift_engine u_engine (
    .clk       (clk),
    .rst       (rst),
    .go_i      (ctrl_q[CTRL_GO]),
    .tx_data_i (tx_q),
    .len_i     (char_len(ctrl_q[CTRL_LEN_MSB:0])),
    .lsb_i     (ctrl_q[CTRL_LSB]),
    .tx_neg_i  (ctrl_q[CTRL_TX_NEG]),
    .rx_neg_i  (ctrl_q[CTRL_RX_NEG]),
    .divider_i (div_q),
    .state_o   (eng_state),
    .sclk_o    (dbg_sclk_o),
    .done_o    (eng_done),
    .rx_word_o (rx_word)
  );

  // With ASS the selects are only asserted for the duration of RUN.
  assign dbg_ss_n_o = (ctrl_q[CTRL_ASS] && (eng_state != ST_RUN)) ? 8'hFF : ~ss_q;
  assign dbg_state_o        = eng_state;
  assign dbg_ctrl_o         = ctrl_q;
  assign host.hostinterrupt = eng_done && ctrl_q[CTRL_IE];
  assign host.lastWrite     = last_write_q;

  logic [FIFO_DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0]  count_q;
  logic                   push, pop;

  assign push = eng_done && (count_q != FIFO_FULL_CNT);
  assign pop  = host.readFifo && (count_q != '0);
  assign dbg_fifo_count_o = count_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst || host.rstFifo) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SPI_FIFO_FWFT_EN
  // Head is shown combinationally; when empty, the last shown word is held.
  logic [31:0] hold_q;
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= host.dout;
  end
  assign host.dout = (count_q != '0) ? fifo_mem[rd_ptr_q] : hold_q;
`else
  logic [31:0] dout_q;
  always_ff @(posedge clk) begin
    if (rst)      dout_q <= '0;
    else if (pop) dout_q <= fifo_mem[rd_ptr_q];
  end
  assign host.dout = dout_q;
`endif

endmodule

// File: tb/tb_spi_host_bridge.sv
// Directed bench for spi_host_bridge: drivers push expected dout words and
// interrupt cycles into queues that a negedge monitor pops and compares.
module tb_spi_host_bridge;
  import spi_host_bridge_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_host_bridge_if host_if ();
  engine_state_e         dbg_state;
  logic [FIFO_CNT_W-1:0] dbg_fifo_count;
  logic                  dbg_sclk;
  logic [7:0]            dbg_ss_n;
  logic [CTRL_W-1:0]     dbg_ctrl;

  spi_host_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .host             (host_if),
    .dbg_state_o      (dbg_state),
    .dbg_fifo_count_o (dbg_fifo_count),
    .dbg_sclk_o       (dbg_sclk),
    .dbg_ss_n_o       (dbg_ss_n),
    .dbg_ctrl_o       (dbg_ctrl)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];
  int          irq_exp_q[$];
  logic        pend_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (pend_rd) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dout_unexpected: got %h with no expectation", host_if.dout);
      end else begin
        check("dout", host_if.dout, exp_q.pop_front());
      end
    end
    pend_rd = host_if.readFifo;
    if (host_if.hostinterrupt === 1'b1) begin
      if (irq_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL irq_unexpected: pulse at cycle %0d expected none", cyc);
      end else begin
        check("irq_cycle", cyc, irq_exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] w);
    host_if.ep_dataout = w;
    host_if.trigger    = 1'b1;
    tick();
    host_if.trigger    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cmd(32'h8000_0000 | {24'h0, a});
    cmd(32'h4000_0000 | d);
  endtask

  task automatic go(input logic [31:0] ctrl, input int irq_lat);
    wr(8'h41, ctrl);
    if (irq_lat > 0) irq_exp_q.push_back(cyc + irq_lat);
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (dbg_state != ST_IDLE && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (dbg_state != ST_IDLE) begin
      bad++;
      $display("FAIL engine_idle_timeout: state %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic pop(input logic [31:0] exp);
    exp_q.push_back(exp);
    host_if.readFifo = 1'b1;
    tick();
    host_if.readFifo = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host_if.ep_dataout = '0;
    host_if.trigger    = 1'b0;
    host_if.readFifo   = 1'b0;
    host_if.rstFifo    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_dout", host_if.dout, 32'h0);
    check("reset_lastWrite", host_if.lastWrite, 32'h0);
    check("reset_irq", {31'h0, host_if.hostinterrupt}, 32'h0);
    check("reset_fifo_count", dbg_fifo_count, 0);
    check("reset_state", dbg_state, ST_IDLE);

    // configure: DIV=1, TX=0x8AA5, CTRL ASS|IE|TX_NEG|RX_NEG len16, SS=1
    wr(8'h51, 32'h1);
    wr(8'h01, 32'h8AA5);
    wr(8'h41, 32'h3610);
    wr(8'h61, 32'h1);
    check("ss_n_idle_ass", dbg_ss_n, 32'hFF);
    go(32'h3710, 65);
    tick();
    check("ss_n_run_ass", dbg_ss_n, 32'hFE);
    wait_idle();
    check("fifo_count_1", dbg_fifo_count, 1);
    check("lastWrite_go", host_if.lastWrite, 32'h4000_3710);
    check("go_cleared", dbg_ctrl, 32'h3610);

    wr(8'h01, 32'h5A01);
    go(32'h3710, 65);
    wait_idle();
    wr(8'h01, 32'h5238);
    go(32'h3710, 65);
    wait_idle();
    check("fifo_count_3", dbg_fifo_count, 3);
    pop(32'h0000_8AA5);
    pop(32'h0000_5A01);
    pop(32'h0000_5238);
    tick();
    check("fifo_count_drained", dbg_fifo_count, 0);

    // rstFifo clears the FIFO only; registers survive
    wr(8'h01, 32'h0777);
    go(32'h3710, 65);
    wait_idle();
    check("fifo_count_pre_clear", dbg_fifo_count, 1);
    host_if.rstFifo = 1'b1;
    tick();
    host_if.rstFifo = 1'b0;
    check("fifo_count_cleared", dbg_fifo_count, 0);
    check("ctrl_after_rstFifo", dbg_ctrl, 32'h3610);
    pop(32'h0000_5238);
    tick();

    // TX and DIVIDER writes while busy are dropped
    wr(8'h01, 32'h00C3);
    go(32'h3710, 65);
    repeat (5) tick();
    wr(8'h01, 32'h1234);
    wr(8'h51, 32'h7);
    wait_idle();
    pop(32'h0000_00C3);

    // LSB-first 8-bit, drive on fall / sample on rise; addr[0]=0 write dropped
    wr(8'h01, 32'h01A5);
    wr(8'h00, 32'h0077);
    go(32'h1D08, 33);
    wait_idle();
    pop(32'h0000_00A5);

    // CHAR_LEN=0 means 32 bits, DIV=0, top two TX bits forced to zero
    wr(8'h51, 32'h0);
    wr(8'h01, 32'h7EAD_BEEF);
    go(32'h1300, 65);
    wait_idle();
    pop(32'h3EAD_BEEF);
    tick();

    // 17 transfers without IE: 16 stored, 17th dropped
    wr(8'h51, 32'h1);
    wr(8'h41, 32'h2010);
    for (int i = 0; i < 17; i++) begin
      wr(8'h01, 32'h1000 + i);
      go(32'h2110, 0);
      wait_idle();
    end
    check("fifo_count_full", dbg_fifo_count, 16);
    for (int i = 0; i < 16; i++) pop(32'h1000 + i);
    pop(32'h0000_100F);
    tick();
    check("fifo_count_after_full_drain", dbg_fifo_count, 0);

    // reset mid-transfer: abort with no push and no interrupt
    wr(8'h01, 32'h0055);
    go(32'h3710, 0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_fifo_count", dbg_fifo_count, 0);
    check("abort_lastWrite", host_if.lastWrite, 32'h0);
    check("abort_dout", host_if.dout, 32'h0);
    check("abort_ctrl", dbg_ctrl, 32'h0);
    repeat (80) tick();

    check("irq_queue_drained", irq_exp_q.size(), 0);
    check("dout_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
